card_dealer: RTL

- Sits directly downstream of the rng block in the blackjack datapath.
- On each deal request it pulses the rng enable, captures the 32-bit random number and maps it onto the cards still in the shoe.
- It removes the chosen card (draw without replacement) and presents its rank, suit and blackjack points to the game controller.
- A shuffle command restores the full 52-card deck.

---
 rtl/card_pkg.sv | 33 +++
 rtl/card_dealer_if.sv | 26 ++
 rtl/card_decode.sv | 16 +
 rtl/card_dealer.sv | 75 +++++++
 4 files changed

// File: rtl/card_pkg.sv
// card_pkg: shared deck constants, FSM states and card-code helpers for the blackjack datapath.
package card_pkg;
    localparam int DECK_SIZE = 52;
    localparam int CARD_W = 6;
    localparam logic [3:0] RANK_ACE = 4'd1;
    localparam logic [3:0] RANK_TEN = 4'd10;
    localparam logic [3:0] RANK_JACK = 4'd11;
    localparam logic [3:0] RANK_QUEEN = 4'd12;
    localparam logic [3:0] RANK_KING = 4'd13;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, PICK} state_t;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

    // Suit boundaries are compared instead of dividing by 13.
    function automatic card_t code_to_rank_suit(input logic [CARD_W-1:0] code);
        card_t c;
        logic [CARD_W-1:0] r;
        c.suit = code >= CARD_W'(39) ? 2'd3 : code >= CARD_W'(26) ? 2'd2 : code >= CARD_W'(13) ? 2'd1 : 2'd0;
        r = code >= CARD_W'(39) ? code - CARD_W'(39) :
            code >= CARD_W'(26) ? code - CARD_W'(26) :
            code >= CARD_W'(13) ? code - CARD_W'(13) : code;
        c.rank = r[3:0] + RANK_ACE;
        return c;
    endfunction

    function automatic logic [3:0] rank_to_points(input logic [3:0] rank);
        return rank > RANK_TEN ? RANK_TEN : rank;
    endfunction
endpackage

// File: rtl/card_dealer_if.sv
// card_dealer_if: controller/rng-facing signals of the card dealer.
interface card_dealer_if;
    logic        shuffle_i;
    logic        deal_req_i;
    logic [31:0] number_i;
    logic        rng_enable_o;
    logic        busy_o;
    logic        deal_valid_o;
    logic [3:0]  card_rank_o;
    logic [1:0]  card_suit_o;
    logic [3:0]  card_points_o;
    logic [5:0]  remaining_o;
    logic        empty_err_o;

    modport master (
        output shuffle_i, deal_req_i, number_i,
        input  rng_enable_o, busy_o, deal_valid_o, card_rank_o, card_suit_o,
               card_points_o, remaining_o, empty_err_o
    );

    modport slave (
        input  shuffle_i, deal_req_i, number_i,
        output rng_enable_o, busy_o, deal_valid_o, card_rank_o, card_suit_o,
               card_points_o, remaining_o, empty_err_o
    );
endinterface

// File: rtl/card_decode.sv
// card_decode: combinational card code to rank, suit and blackjack points.
module card_decode
    import card_pkg::*;
(
    input  logic [CARD_W-1:0] code,
    output logic [3:0]        rank,
    output logic [1:0]        suit,
    output logic [3:0]        points
);
    card_t c;

    assign c = code_to_rank_suit(code);
    assign rank = c.rank;
    assign suit = c.suit;
    assign points = rank_to_points(c.rank);
endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals cards without replacement from a 52-card shoe,
// scaling each rng word onto the cards still remaining.
module card_dealer
    import card_pkg::*;
#(
    parameter int RNG_LAT = 1
) (
    input logic clk,
    input logic reset,
    card_dealer_if.slave bus
);
    localparam int CNT_W = $clog2(RNG_LAT + 1);

    state_t state, next;
    logic [CNT_W-1:0] cnt;
    logic [CARD_W-1:0] deck [DECK_SIZE];
    logic [CARD_W-1:0] remaining, last, idx;
    logic [21:0] prod;
    logic [3:0] rank, points;
    logic [1:0] suit;
    logic clear;

    assign clear = reset || bus.shuffle_i;
    assign last = remaining - CARD_W'(1);
    // Scaling the low half-word by the shoe size keeps idx below remaining without a divider.
    assign prod = {6'd0, bus.number_i[15:0]} * {16'd0, remaining};
    assign idx = prod[21:16];
    assign bus.remaining_o = remaining;
    assign bus.rng_enable_o = state == REQ;
    assign bus.busy_o = state != IDLE;

    card_decode u_decode (
        .code(deck[idx]),
        .rank(rank),
        .suit(suit),
        .points(points)
    );

    always_ff @(posedge clk) begin
        state <= clear ? IDLE : next;
        cnt <= state == WAIT ? cnt + CNT_W'(1) : '0;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: next = bus.deal_req_i && remaining != '0 ? REQ : IDLE;
            REQ: next = WAIT;
            WAIT: next = cnt == CNT_W'(RNG_LAT - 1) ? PICK : WAIT;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DECK_SIZE; i++) deck[i] <= CARD_W'(i);
            remaining <= CARD_W'(DECK_SIZE);
            bus.deal_valid_o <= 1'b0;
            bus.empty_err_o <= 1'b0;
            bus.card_rank_o <= '0;
            bus.card_suit_o <= '0;
            bus.card_points_o <= '0;
        end else begin
            bus.deal_valid_o <= state == PICK;
            bus.empty_err_o <= state == IDLE && bus.deal_req_i && remaining == '0;
            if (state == PICK) begin
                bus.card_rank_o <= rank;
                bus.card_suit_o <= suit;
                bus.card_points_o <= points;
                deck[idx] <= deck[last];
                remaining <= last;
            end
        end
    end
endmodule
